// File: rtl/sr_mul_pkg.sv
// Shared types and step-count constants for the sequential shift-add multiplier.
// Step counts are for the default 32-bit width; bits retired per step derive from them.
package sr_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   localparam int MUL_W_DEFAULT = 32;
   localparam int MUL_STEPS_R2  = MUL_W_DEFAULT;
   localparam int MUL_STEPS_R4  = MUL_W_DEFAULT / 2;
   localparam int MUL_BITS_R2   = MUL_W_DEFAULT / MUL_STEPS_R2;
   localparam int MUL_BITS_R4   = MUL_W_DEFAULT / MUL_STEPS_R4;

endpackage

// File: rtl/sr_mul_if.sv
// Handshake and operand/result bundle between the decode stage and the multiplier.
// The multiplier takes the slave side; the decode stage (or bench) takes the master side.
interface sr_mul_if #(
   parameter int DATA_W = 32
) ();

   logic              start;
   logic [DATA_W-1:0] srcA;
   logic [DATA_W-1:0] srcB;
   logic [DATA_W-1:0] result;
   logic              vld;
   logic              busy;
   logic              stall;

   modport master (
      output start, srcA, srcB,
      input  result, vld, busy, stall
   );

   modport slave (
      input  start, srcA, srcB,
      output result, vld, busy, stall
   );

endinterface

// File: rtl/sr_mul_step.sv
// One combinational shift-add step: adds mcand<<i for every set multiplier bit i.
// BITS=1 gives a radix-2 step, BITS=2 a radix-4 step.
module sr_mul_step #(
   parameter int DATA_W = 32,
   parameter int BITS   = 1
) (
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] mcand,
   input  logic [BITS-1:0]   mplier_bits,
   output logic [DATA_W-1:0] acc_next
);

   logic [BITS:0][DATA_W-1:0] sum;

   assign sum[0] = acc;

   generate
      for (genvar gi = 0; gi < BITS; gi++) begin : g_pp
         assign sum[gi+1] = sum[gi] + (mplier_bits[gi] ? (mcand << gi) : '0);
      end
   endgenerate

   assign acc_next = sum[BITS];

endmodule

// File: rtl/sr_mul_seq.sv
// Iterative unsigned multiplier (low DATA_W bits of srcA*srcB) with IDLE/BUSY/DONE FSM.
// Define SR_MUL_RADIX4_EN to retire two multiplier bits per cycle (half the latency).
module sr_mul_seq
   import sr_mul_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic     clk,
   input  logic     rst,
   sr_mul_if.slave  bus
);

`ifdef SR_MUL_RADIX4_EN
   localparam int BITS = MUL_BITS_R4;
`else
   localparam int BITS = MUL_BITS_R2;
`endif
   localparam int STEPS = DATA_W / BITS;
   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   mul_state_t        state_reg;
   mul_state_t        state_next;
   logic [DATA_W-1:0] acc_reg;
   logic [DATA_W-1:0] acc_next;
   logic [DATA_W-1:0] mcand_reg;
   logic [DATA_W-1:0] mplier_reg;
   logic [DATA_W-1:0] result_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              last_step;
   logic              vld;

   assign last_step = (cnt_reg == LAST_STEP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = BUSY;
         BUSY:    if (last_step) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   sr_mul_step #(
      .DATA_W (DATA_W),
      .BITS   (BITS)
   ) u_step (
      .acc         (acc_reg),
      .mcand       (mcand_reg),
      .mplier_bits (mplier_reg[BITS-1:0]),
      .acc_next    (acc_next)
   );

   // result only moves on the final step, so it holds across IDLE and BUSY
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         cnt_reg    <= '0;
         result_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  mcand_reg  <= bus.srcA;
                  mplier_reg <= bus.srcB;
                  acc_reg    <= '0;
                  cnt_reg    <= '0;
               end
            end
            BUSY: begin
               acc_reg    <= acc_next;
               mcand_reg  <= mcand_reg << BITS;
               mplier_reg <= mplier_reg >> BITS;
               cnt_reg    <= cnt_reg + CNT_W'(1);
               if (last_step) begin
                  result_reg <= acc_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign vld        = (state_reg == DONE);
   assign bus.vld    = vld;
   assign bus.busy   = (state_reg != IDLE);
   assign bus.result = result_reg;
   assign bus.stall  = bus.start & ~vld;

endmodule

// File: tb/tb_sr_mul_seq.sv
// Directed and random checks of sr_mul_seq: latency, stall, hold, back-to-back, reset abort.
// Expected latency follows SR_MUL_RADIX4_EN; products are hand-computed or a*b truncated.
module tb_sr_mul_seq;

`ifdef SR_MUL_RADIX4_EN
   localparam int LAT = 17;
`else
   localparam int LAT = 33;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   sr_mul_if #(.DATA_W(32)) bus ();

   sr_mul_seq #(.DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives one MUL and waits (bounded) for vld; lat = -1 on timeout.
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      bus.srcA  = a;
      bus.srcB  = b;
      bus.start = 1'b1;
      lat = -1;
      res = '0;
      for (int n = 1; n <= LAT + 8; n++) begin
         tick;
         if (bus.vld === 1'b1) begin
            res = bus.result;
            lat = n;
            break;
         end
      end
      bus.start = 1'b0;
      tick;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.srcA = '0;
      bus.srcB = '0;
      tick;
      tick;
      checks++; if (bus.vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", bus.vld); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall); end
      rst = 1'b0;
      tick;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_no_start_busy got %b want 0", bus.busy); end
      $display("txn reset: vld=%b busy=%b result=%h", bus.vld, bus.busy, bus.result);
   endtask

   task automatic test_basic;
      bus.srcA  = 32'd6;
      bus.srcB  = 32'd7;
      bus.start = 1'b1;
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL basic_stall_t0 got %b want 1", bus.stall); end
      for (int k = 1; k <= LAT; k++) begin
         tick;
         checks++;
         if (bus.vld !== (k == LAT)) begin errors++; $display("FAIL basic_vld cyc %0d got %b want %b", k, bus.vld, (k == LAT)); end
         checks++;
         if (bus.stall !== (k != LAT)) begin errors++; $display("FAIL basic_stall cyc %0d got %b want %b", k, bus.stall, (k != LAT)); end
         if (k == LAT - 1) begin
            checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL basic_result_early got %0d want 0", bus.result); end
         end
         if (k == LAT) begin
            checks++; if (bus.result !== 32'd42) begin errors++; $display("FAIL basic_result got %0d want 42", bus.result); end
         end
      end
      bus.start = 1'b0;
      tick;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_back_idle busy got %b want 0", bus.busy); end
      checks++; if (bus.vld !== 1'b0) begin errors++; $display("FAIL basic_vld_once got %b want 0", bus.vld); end
      $display("txn 6*7 -> %0d latency %0d", bus.result, LAT);
   endtask

   task automatic test_corners;
      logic [31:0] res;
      int lat;
      do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
      checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL ones_result got %h want 00000001", res); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL ones_latency got %0d want %0d", lat, LAT); end
      $display("txn ffffffff*ffffffff -> %h latency %0d", res, lat);
      do_mul(32'h8000_0000, 32'd2, res, lat);
      checks++; if (res !== 32'h0000_0000) begin errors++; $display("FAIL msb_result got %h want 00000000", res); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL msb_latency got %0d want %0d", lat, LAT); end
      $display("txn 80000000*2 -> %h latency %0d", res, lat);
   endtask

   task automatic test_operand_change;
      bus.srcA  = 32'd3;
      bus.srcB  = 32'd5;
      bus.start = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         tick;
         if (k == 5) begin
            bus.srcB  = 32'd0;
            bus.srcA  = 32'h1234;
            bus.start = 1'b0;
         end
         if (k == LAT) begin
            checks++; if (bus.vld !== 1'b1) begin errors++; $display("FAIL chg_vld got %b want 1", bus.vld); end
            checks++; if (bus.result !== 32'd15) begin errors++; $display("FAIL chg_result got %0d want 15", bus.result); end
         end
      end
      tick;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL chg_idle busy got %b want 0", bus.busy); end
      $display("txn 3*5 (operands changed mid-op) -> %0d", bus.result);
   endtask

   task automatic test_back_to_back;
      bus.srcA  = 32'd3;
      bus.srcB  = 32'd4;
      bus.start = 1'b1;
      for (int k = 1; k <= 2 * LAT + 1; k++) begin
         tick;
         if (k == LAT) begin
            checks++; if (bus.vld !== 1'b1) begin errors++; $display("FAIL b2b_vld1 got %b want 1", bus.vld); end
            checks++; if (bus.result !== 32'd12) begin errors++; $display("FAIL b2b_result1 got %0d want 12", bus.result); end
            checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_done got %b want 0", bus.stall); end
            bus.srcA = 32'd5;
            bus.srcB = 32'd5;
         end else if (k > LAT && k <= 2 * LAT) begin
            checks++; if (bus.vld !== 1'b0) begin errors++; $display("FAIL b2b_vld_gap cyc %0d got %b want 0", k, bus.vld); end
            checks++; if (bus.result !== 32'd12) begin errors++; $display("FAIL b2b_hold cyc %0d got %0d want 12", k, bus.result); end
            if (k == LAT + 1) begin
               checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy got %b want 0", bus.busy); end
            end
            if (k == LAT + 2) begin
               checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_restart busy got %b want 1", bus.busy); end
            end
         end else if (k == 2 * LAT + 1) begin
            checks++; if (bus.vld !== 1'b1) begin errors++; $display("FAIL b2b_vld2 got %b want 1", bus.vld); end
            checks++; if (bus.result !== 32'd25) begin errors++; $display("FAIL b2b_result2 got %0d want 25", bus.result); end
            bus.start = 1'b0;
         end
      end
      tick;
      $display("txn 3*4 then 5*5 back-to-back -> %0d", bus.result);
   endtask

   task automatic test_reset_mid;
      bus.srcA  = 32'd9;
      bus.srcB  = 32'd9;
      bus.start = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick;
         checks++;
         if (bus.vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld cyc %0d got %b want 0", k, bus.vld); end
         if (k == 10) begin
            rst = 1'b1;
            bus.start = 1'b0;
         end
         if (k == 11) begin
            rst = 1'b0;
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
            checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL rstmid_result got %0d want 0", bus.result); end
         end
      end
      $display("txn 9*9 aborted by reset: busy=%b result=%0d", bus.busy, bus.result);
   endtask

   task automatic test_random;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expv;
      logic [31:0] res;
      int lat;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         b = $urandom;
         expv = a * b;
         do_mul(a, b, res, lat);
         checks++;
         if (res !== expv) begin errors++; $display("FAIL rand_result %h*%h got %h want %h", a, b, res, expv); end
         checks++;
         if (lat != LAT) begin errors++; $display("FAIL rand_latency %h*%h got %0d want %0d", a, b, lat, LAT); end
         $display("txn rand %0d: %h*%h -> %h", i, a, b, res);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_corners;
      test_operand_change;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
